ansi_term_engine: RTL and testbench

Byte-stream terminal engine between `uart_rx` (upstream) and `vga_text_mode` (downstream). It consumes received characters, tracks the cursor, and parses ESC/CSI sequences with numeric parameters. It issues single-cell writes and blit/clear requests to the text buffer, handling line wrap and scroll.

---
 rtl/term_pkg.sv | 31 +++
 rtl/csi_param_acc.sv | 43 ++++
 rtl/ansi_term_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_ansi_term_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// Shared types and constants for the ANSI terminal engine: parser states,
// control byte codes, default geometry and the saturating decimal accumulate.
package term_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ESC,
    ST_CSI,
    ST_EXEC,
    ST_BLIT_WAIT,
    ST_SCROLL1,
    ST_SCROLL2
  } term_state_t;

  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 25;

  // p*10+d, pinned at 255 once it overflows.
  function automatic logic [7:0] acc_digit(input logic [7:0] p, input logic [3:0] d);
    logic [11:0] t;
    t = 12'(p) * 12'd10 + 12'(d);
    return (t > 12'd255) ? 8'hFF : t[7:0];
  endfunction

endpackage

// File: rtl/csi_param_acc.sv
// CSI numeric parameter collector: two saturating decimal accumulators plus
// a parameter index; anything after the second parameter is discarded.
module csi_param_acc
  import term_pkg::*;
(
  input  logic       clk100,
  input  logic       rst,
  input  logic       clr,
  input  logic       digit_en,
  input  logic [3:0] digit,
  input  logic       sep,
  output logic [7:0] p0,
  output logic [7:0] p1
);

  logic [1:0] idx_reg;
  logic [7:0] p0_reg;
  logic [7:0] p1_reg;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
      p0_reg  <= '0;
      p1_reg  <= '0;
    end else if (clr) begin
      idx_reg <= '0;
      p0_reg  <= '0;
      p1_reg  <= '0;
    end else if (sep) begin
      if (idx_reg != 2'd2) idx_reg <= idx_reg + 2'd1;
    end else if (digit_en) begin
      case (idx_reg)
        2'd0:    p0_reg <= acc_digit(p0_reg, digit);
        2'd1:    p1_reg <= acc_digit(p1_reg, digit);
        default: ;
      endcase
    end
  end

  assign p0 = p0_reg;
  assign p1 = p1_reg;

endmodule

// File: rtl/ansi_term_engine.sv
// Byte-stream terminal engine: cursor tracking, ESC/CSI parsing, cell writes
// and blit/clear requests (including scroll) towards the text buffer.
module ansi_term_engine
  import term_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        blit_en,
  output logic [10:0] blit_start,
  output logic [10:0] blit_end,
  output logic [7:0]  blit_offset,
  input  logic        blit_complete,
  output logic [5:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy,
  output logic        overrun
);

  localparam logic [10:0] COLS11    = 11'(COLS);
  localparam logic [10:0] TOTAL     = 11'(ROWS * COLS);
  localparam logic [10:0] LAST_BASE = 11'((ROWS - 1) * COLS);
  localparam logic [5:0]  ROW_MAX   = 6'(ROWS - 1);
  localparam logic [6:0]  COL_MAX   = 7'(COLS - 1);
  localparam logic [7:0]  OFF_COLS  = 8'(COLS);

  term_state_t state_reg, state_next;
  logic [5:0]  row_reg, row_next;
  logic [6:0]  col_reg, col_next;
  logic [7:0]  final_reg, final_next;
  logic        wr_en_reg, wr_en_next;
  logic [10:0] wr_addr_reg, wr_addr_next;
  logic [7:0]  wr_data_reg, wr_data_next;
  logic        blit_en_reg, blit_en_next;
  logic [10:0] blit_start_reg, blit_start_next;
  logic [10:0] blit_end_reg, blit_end_next;
  logic [7:0]  blit_off_reg, blit_off_next;
  logic        skid_full_reg, skid_full_next;
  logic [7:0]  skid_data_reg, skid_data_next;
  logic        overrun_reg, overrun_next;

  logic        acc_clr, acc_digit_en, acc_sep, advance_row;
  logic [7:0]  p0, p1, n0, n1, h_row, h_col;
  logic [8:0]  row_sum, col_sum;
  logic [10:0] row_base, cur_addr;
  logic        take, cplt;
  logic [7:0]  in_byte;

  csi_param_acc u_params (
    .clk100   (clk100),
    .rst      (rst),
    .clr      (acc_clr),
    .digit_en (acc_digit_en),
    .digit    (in_byte[3:0]),
    .sep      (acc_sep),
    .p0       (p0),
    .p1       (p1)
  );

  assign busy     = wr_en_reg || (state_reg inside {ST_EXEC, ST_BLIT_WAIT, ST_SCROLL1, ST_SCROLL2});
  assign take     = !busy && (skid_full_reg || rx_valid);
  assign in_byte  = skid_full_reg ? skid_data_reg : rx_data;
  // A completion in the same cycle as the request belongs to an older blit.
  assign cplt     = blit_complete && !blit_en_reg;
  assign n0       = (p0 == 8'd0) ? 8'd1 : p0;
  assign n1       = (p1 == 8'd0) ? 8'd1 : p1;
  assign h_row    = n0 - 8'd1;
  assign h_col    = n1 - 8'd1;
  assign row_sum  = {3'b0, row_reg} + {1'b0, n0};
  assign col_sum  = {2'b0, col_reg} + {1'b0, n0};
  assign row_base = 11'(row_reg) * COLS11;
  assign cur_addr = row_base + 11'(col_reg);

  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    col_next        = col_reg;
    final_next      = final_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    blit_en_next    = 1'b0;
    blit_start_next = blit_start_reg;
    blit_end_next   = blit_end_reg;
    blit_off_next   = blit_off_reg;
    skid_full_next  = skid_full_reg;
    skid_data_next  = skid_data_reg;
    overrun_next    = overrun_reg;
    acc_clr         = 1'b0;
    acc_digit_en    = 1'b0;
    acc_sep         = 1'b0;
    advance_row     = 1'b0;

    if (busy) begin
      if (rx_valid) begin
        if (skid_full_reg) overrun_next = 1'b1;
        else begin
          skid_full_next = 1'b1;
          skid_data_next = rx_data;
        end
      end
    end else if (skid_full_reg) begin
      skid_full_next = rx_valid;
      if (rx_valid) skid_data_next = rx_data;
    end

    case (state_reg)
      ST_IDLE: if (take) begin
        if (in_byte >= CH_SPACE && in_byte <= 8'h7E) begin
          wr_en_next   = 1'b1;
          wr_addr_next = cur_addr;
          wr_data_next = in_byte;
          if (col_reg == COL_MAX) begin
            col_next    = '0;
            advance_row = 1'b1;
          end else col_next = col_reg + 7'd1;
        end else if (in_byte == CH_LF) advance_row = 1'b1;
        else if (in_byte == CH_CR) col_next = '0;
        else if (in_byte == CH_BS) begin
          if (col_reg != 7'd0) col_next = col_reg - 7'd1;
        end else if (in_byte == CH_ESC) state_next = ST_ESC;
      end
      ST_ESC: if (take) begin
        if (in_byte == "[") begin
          state_next = ST_CSI;
          acc_clr    = 1'b1;
        end else state_next = ST_IDLE;
      end
      ST_CSI: if (take) begin
        if (in_byte >= "0" && in_byte <= "9") acc_digit_en = 1'b1;
        else if (in_byte == ";") acc_sep = 1'b1;
        else if (in_byte >= 8'h40 && in_byte <= 8'h7E) begin
          final_next = in_byte;
          state_next = ST_EXEC;
        end else if (in_byte < 8'h20) state_next = ST_IDLE;
      end
      ST_EXEC: begin
        state_next = ST_IDLE;
        case (final_reg)
          "A": row_next = ({1'b0, n0} > {3'b0, row_reg}) ? 6'd0 : row_reg - n0[5:0];
          "B": row_next = (row_sum > {3'b0, ROW_MAX}) ? ROW_MAX : row_sum[5:0];
          "C": col_next = (col_sum > {2'b0, COL_MAX}) ? COL_MAX : col_sum[6:0];
          "D": col_next = ({1'b0, n0} > {2'b0, col_reg}) ? 7'd0 : col_reg - n0[6:0];
          "H", "f": begin
            row_next = (h_row > {2'b0, ROW_MAX}) ? ROW_MAX : h_row[5:0];
            col_next = (h_col > {1'b0, COL_MAX}) ? COL_MAX : h_col[6:0];
          end
          "J": if (p0 == 8'd0 || p0 == 8'd2) begin
            blit_en_next    = 1'b1;
            blit_start_next = (p0 == 8'd0) ? cur_addr : 11'd0;
            blit_end_next   = TOTAL;
            blit_off_next   = 8'd0;
            state_next      = ST_BLIT_WAIT;
          end
          "K": if (p0 == 8'd0) begin
            blit_en_next    = 1'b1;
            blit_start_next = cur_addr;
            blit_end_next   = row_base + COLS11;
            blit_off_next   = 8'd0;
            state_next      = ST_BLIT_WAIT;
          end
          default: ;
        endcase
      end
      ST_BLIT_WAIT: if (cplt) state_next = ST_IDLE;
      ST_SCROLL1: if (cplt) begin
        blit_en_next    = 1'b1;
        blit_start_next = LAST_BASE;
        blit_end_next   = TOTAL;
        blit_off_next   = 8'd0;
        state_next      = ST_SCROLL2;
      end
      ST_SCROLL2: if (cplt) begin
        row_next   = ROW_MAX;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Stepping past the last row shifts the screen up one line, then blanks it.
    if (advance_row) begin
      row_next = row_reg + 6'd1;
      if (row_reg == ROW_MAX) begin
        state_next      = ST_SCROLL1;
        blit_en_next    = 1'b1;
        blit_start_next = 11'd0;
        blit_end_next   = LAST_BASE;
        blit_off_next   = OFF_COLS;
      end
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      row_reg        <= '0;
      col_reg        <= '0;
      final_reg      <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      blit_en_reg    <= 1'b0;
      blit_start_reg <= '0;
      blit_end_reg   <= '0;
      blit_off_reg   <= '0;
      skid_full_reg  <= 1'b0;
      skid_data_reg  <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      final_reg      <= final_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      blit_en_reg    <= blit_en_next;
      blit_start_reg <= blit_start_next;
      blit_end_reg   <= blit_end_next;
      blit_off_reg   <= blit_off_next;
      skid_full_reg  <= skid_full_next;
      skid_data_reg  <= skid_data_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign blit_en     = blit_en_reg;
  assign blit_start  = blit_start_reg;
  assign blit_end    = blit_end_reg;
  assign blit_offset = blit_off_reg;
  assign cursor_row  = row_reg;
  assign cursor_col  = col_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_ansi_term_engine.sv
// Directed bench for ansi_term_engine: text, wrap, cursor control, erase,
// scroll, skid/overrun and reset during an outstanding blit.
module tb_ansi_term_engine;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        blit_complete = 1'b0;
  logic        wr_en, blit_en, busy, overrun;
  logic [10:0] wr_addr, blit_start, blit_end;
  logic [7:0]  wr_data, blit_offset;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {logic [10:0] a; logic [7:0] d;} wr_t;
  wr_t wq[$];

  ansi_term_engine dut (
    .clk100        (clk100),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .blit_en       (blit_en),
    .blit_start    (blit_start),
    .blit_end      (blit_end),
    .blit_offset   (blit_offset),
    .blit_complete (blit_complete),
    .cursor_row    (cursor_row),
    .cursor_col    (cursor_col),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk100 = ~clk100;

  always @(negedge clk100) if (!rst && wr_en === 1'b1) wq.push_back({wr_addr, wr_data});

  task automatic idle(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk100); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk100); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_csi(input string s);
    send_byte(8'h1B);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset;
    rx_valid = 1'b0;
    blit_complete = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    wq.delete();
  endtask

  task automatic wait_blit(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (blit_en === 1'b1) ok = 1'b1;
      else begin
        @(posedge clk100); #1;
      end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL blit_timeout: no blit_en within 50 cycles, required one"); end
  endtask

  task automatic pulse_complete;
    @(posedge clk100); #1;
    blit_complete = 1'b1;
    @(posedge clk100); #1;
    blit_complete = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    n_checks++; if ({wr_en, blit_en, busy, overrun} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b required 0000", {wr_en, blit_en, busy, overrun}); end
    n_checks++; if ({wr_addr, wr_data} !== 19'd0) begin n_fail++; $display("FAIL reset_wr: got addr %0d data %h required 0/00", wr_addr, wr_data); end
    n_checks++; if ({blit_start, blit_end, blit_offset} !== 30'd0) begin n_fail++; $display("FAIL reset_blit: got %0d/%0d/%0d required 0/0/0", blit_start, blit_end, blit_offset); end
    n_checks++; if ({cursor_row, cursor_col} !== 13'd0) begin n_fail++; $display("FAIL reset_cursor: got %0d,%0d required 0,0", cursor_row, cursor_col); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_text;
    do_reset();
    send_byte("A");
    n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 11'd0, 8'h41}) begin n_fail++; $display("FAIL first_write_timing: got en %b addr %0d data %h required 1/0/41", wr_en, wr_addr, wr_data); end
    n_checks++; if ({busy, cursor_col} !== {1'b1, 7'd1}) begin n_fail++; $display("FAIL first_write_cursor: got busy %b col %0d required 1/1", busy, cursor_col); end
    send_byte("B");
    send_byte(8'h0D);
    send_byte(8'h0A);
    idle(3);
    n_checks++; if (wq.size() != 2) begin n_fail++; $display("FAIL text_count: got %0d writes required 2", wq.size()); end
    n_checks++; if ((wq.size() > 1 ? wq[1] : wr_t'(0)) !== {11'd1, 8'h42} || wq[0] !== {11'd0, 8'h41}) begin n_fail++; $display("FAIL text_writes: got %h %h required 00041 00142", wq[0], wq[1]); end
    n_checks++; if ({cursor_row, cursor_col} !== {6'd1, 7'd0}) begin n_fail++; $display("FAIL text_cursor: got %0d,%0d required 1,0", cursor_row, cursor_col); end
    send_byte(8'h08);
    idle(1);
    n_checks++; if (cursor_col !== 7'd0) begin n_fail++; $display("FAIL bs_saturate: got col %0d required 0", cursor_col); end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 81; i++) send_byte(8'h21 + 8'(i % 94));
    idle(2);
    n_checks++; if (wq.size() != 81) begin n_fail++; $display("FAIL wrap_count: got %0d writes required 81", wq.size()); end
    n_checks++; if ((wq.size() > 80 ? wq[80] : wr_t'(0)) !== {11'd80, 8'h71}) begin n_fail++; $display("FAIL wrap_81st: got %h required %h", (wq.size() > 80 ? wq[80] : wr_t'(0)), {11'd80, 8'h71}); end
    n_checks++; if ((wq.size() > 79 ? wq[79] : wr_t'(0)) !== {11'd79, 8'h70}) begin n_fail++; $display("FAIL wrap_80th: got %h required %h", (wq.size() > 79 ? wq[79] : wr_t'(0)), {11'd79, 8'h70}); end
    n_checks++; if ({cursor_row, cursor_col} !== {6'd1, 7'd1}) begin n_fail++; $display("FAIL wrap_cursor: got %0d,%0d required 1,1", cursor_row, cursor_col); end
  endtask

  task automatic test_cup;
    do_reset();
    send_csi("[12;40H");
    idle(2);
    n_checks++; if ({cursor_row, cursor_col} !== {6'd11, 7'd39}) begin n_fail++; $display("FAIL cup_cursor: got %0d,%0d required 11,39", cursor_row, cursor_col); end
    send_byte("x");
    idle(2);
    n_checks++; if (wq.size() != 1 || wq[0] !== {11'd919, 8'h78}) begin n_fail++; $display("FAIL cup_write: got %0d writes first %h required 1 write %h", wq.size(), wq[0], {11'd919, 8'h78}); end
  endtask

  task automatic test_cursor_moves;
    string seq [10] = '{"[5;10H", "[2A", "[B", "[D", "[99D", "[999C", "[99B", "[H", "[?25h", "[40;100f"};
    int exp_row [10] = '{4, 2, 3, 3, 3, 3, 24, 0, 0, 24};
    int exp_col [10] = '{9, 9, 9, 8, 0, 79, 79, 0, 0, 79};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send_csi(seq[i]);
      idle(2);
      n_checks++;
      if (cursor_row !== 6'(exp_row[i]) || cursor_col !== 7'(exp_col[i])) begin
        n_fail++;
        $display("FAIL move_%0d: got %0d,%0d required %0d,%0d", i, cursor_row, cursor_col, exp_row[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_erase;
    bit ok;
    do_reset();
    send_csi("[3;5H");
    send_csi("[K");
    wait_blit(ok);
    idle(3);
    n_checks++; if ({blit_en, blit_start, blit_end, blit_offset} !== {1'b0, 11'd164, 11'd240, 8'd0}) begin n_fail++; $display("FAIL erase_k: got en %b %0d/%0d/%0d required 0 164/240/0", blit_en, blit_start, blit_end, blit_offset); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL erase_wait_busy: got %b required 1", busy); end
    pulse_complete();
    idle(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL erase_done: got busy %b required 0", busy); end
    send_csi("[J");
    wait_blit(ok);
    n_checks++; if ({blit_start, blit_end, blit_offset} !== {11'd164, 11'd2000, 8'd0}) begin n_fail++; $display("FAIL erase_j0: got %0d/%0d/%0d required 164/2000/0", blit_start, blit_end, blit_offset); end
    pulse_complete();
    send_csi("[2J");
    wait_blit(ok);
    n_checks++; if ({blit_start, blit_end, blit_offset} !== {11'd0, 11'd2000, 8'd0}) begin n_fail++; $display("FAIL erase_j2: got %0d/%0d/%0d required 0/2000/0", blit_start, blit_end, blit_offset); end
    pulse_complete();
    idle(2);
    n_checks++; if ({cursor_row, cursor_col, busy} !== {6'd2, 7'd4, 1'b0}) begin n_fail++; $display("FAIL erase_cursor: got %0d,%0d busy %b required 2,4 busy 0", cursor_row, cursor_col, busy); end
  endtask

  task automatic test_scroll;
    bit ok;
    do_reset();
    send_csi("[25H");
    send_byte(8'h0A);
    wait_blit(ok);
    n_checks++; if ({blit_start, blit_end, blit_offset} !== {11'd0, 11'd1920, 8'd80}) begin n_fail++; $display("FAIL scroll1: got %0d/%0d/%0d required 0/1920/80", blit_start, blit_end, blit_offset); end
    blit_complete = 1'b1;
    @(posedge clk100); #1;
    blit_complete = 1'b0;
    idle(3);
    n_checks++; if ({busy, blit_start, blit_end, blit_offset} !== {1'b1, 11'd0, 11'd1920, 8'd80}) begin n_fail++; $display("FAIL scroll_same_cycle_cplt: got busy %b %0d/%0d/%0d required 1 0/1920/80", busy, blit_start, blit_end, blit_offset); end
    pulse_complete();
    wait_blit(ok);
    n_checks++; if ({blit_start, blit_end, blit_offset} !== {11'd1920, 11'd2000, 8'd0}) begin n_fail++; $display("FAIL scroll2: got %0d/%0d/%0d required 1920/2000/0", blit_start, blit_end, blit_offset); end
    pulse_complete();
    idle(2);
    n_checks++; if ({cursor_row, cursor_col, busy} !== {6'd24, 7'd0, 1'b0}) begin n_fail++; $display("FAIL scroll_cursor: got %0d,%0d busy %b required 24,0 busy 0", cursor_row, cursor_col, busy); end
  endtask

  task automatic test_overrun;
    bit ok;
    wq.delete();
    send_byte(8'h0A);
    wait_blit(ok);
    send_byte("p");
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_held: got %b required 0", overrun); end
    send_byte("q");
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b required 1", overrun); end
    send_byte("r");
    pulse_complete();
    wait_blit(ok);
    pulse_complete();
    idle(4);
    n_checks++; if (wq.size() != 1 || wq[0] !== {11'd1920, 8'h70}) begin n_fail++; $display("FAIL overrun_drain: got %0d writes first %h required 1 write %h", wq.size(), wq[0], {11'd1920, 8'h70}); end
    n_checks++; if ({cursor_row, cursor_col, overrun} !== {6'd24, 7'd1, 1'b1}) begin n_fail++; $display("FAIL overrun_after: got %0d,%0d ovr %b required 24,1 ovr 1", cursor_row, cursor_col, overrun); end
  endtask

  task automatic test_reset_mid_blit;
    bit ok;
    send_csi("[2J");
    wait_blit(ok);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    wq.delete();
    n_checks++; if ({busy, blit_en, overrun} !== 3'b000) begin n_fail++; $display("FAIL midblit_reset: got busy/blit/ovr %b required 000", {busy, blit_en, overrun}); end
    pulse_complete();
    idle(2);
    n_checks++; if ({busy, blit_en} !== 2'b00) begin n_fail++; $display("FAIL midblit_stray_cplt: got busy/blit %b required 00", {busy, blit_en}); end
    send_byte("z");
    idle(2);
    n_checks++; if (wq.size() != 1 || wq[0] !== {11'd0, 8'h7A}) begin n_fail++; $display("FAIL midblit_resume: got %0d writes first %h required 1 write %h", wq.size(), wq[0], {11'd0, 8'h7A}); end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_text();
    test_wrap();
    test_cup();
    test_cursor_moves();
    test_erase();
    test_scroll();
    test_overrun();
    test_reset_mid_blit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
